uart_tx_parity: RTL and testbench

//   UART transmitter, the TX counterpart of the processor's UART receive path on risc_v_top.tx.

---
 rtl/uart_tx_parity.sv | 146 ++++++++++++++
 tb/tb_uart_tx_parity.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_parity.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity bit, stop bit.
// Every output is a flop; a request is accepted on any edge where the block is idle.
module uart_tx_parity #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk_50Mhz,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_send,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic baud_end;
  logic par_next;

  assign baud_end = (baud_q == BAUD_LAST);
  // Parity is taken from the byte at acceptance, so later tx_data changes cannot leak in.
  assign par_next = (PARITY_ODD != 0) ? ~^tx_data : ^tx_data;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (state_q != S_IDLE) begin
      baud_d = baud_end ? '0 : baud_q + CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (tx_send) begin
          shift_d = tx_data;
          par_d   = par_next;
          state_d = S_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      S_START: begin
        if (baud_end) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (baud_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d = '0;
            if (PARITY_EN != 0) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (baud_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (baud_end) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_parity.sv
// Bench for uart_tx_parity: even, odd and no-parity instances share one stimulus stream;
// a frame-level model queues expected line waveforms that a monitor checks at each tx_done.
module tb_uart_tx_parity;

  localparam int CPB = 4;
  localparam int ND  = 3;

  logic clk_50Mhz = 1'b0;
  logic rst_n     = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_send = 1'b0;

  logic [ND-1:0] tx_w, busy_w, done_w;

  always #5 clk_50Mhz = ~clk_50Mhz;

  uart_tx_parity #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) dut_even (
    .clk_50Mhz(clk_50Mhz), .rst_n(rst_n), .tx_data(tx_data), .tx_send(tx_send),
    .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));
  uart_tx_parity #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1)) dut_odd (
    .clk_50Mhz(clk_50Mhz), .rst_n(rst_n), .tx_data(tx_data), .tx_send(tx_send),
    .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));
  uart_tx_parity #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0)) dut_nopar (
    .clk_50Mhz(clk_50Mhz), .rst_n(rst_n), .tx_data(tx_data), .tx_send(tx_send),
    .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));

  typedef struct {
    int          len;
    logic [63:0] wave;
    logic [7:0]  data;
    int          acc_cyc;
  } frame_t;

  frame_t q0[$], q1[$], q2[$];
  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int rem [ND];

  task automatic chk(input bit ok, input string name, input int k,
                     input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", name, k, $time, act, exp);
    end
  endtask

  function automatic int frame_bits(input int k);
    return (k == 2) ? 10 : 11;
  endfunction

  // Expected line level for each busy cycle, built straight from the frame format.
  function automatic frame_t build(input int k, input logic [7:0] d, input int c);
    frame_t f;
    logic [10:0] b;
    int nb;
    b = '0;
    nb = frame_bits(k);
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[1+i] = d[i];
    if (k == 2) b[9] = 1'b1;
    else begin
      b[9]  = (k == 1) ? ~^d : ^d;
      b[10] = 1'b1;
    end
    f.wave = '0;
    for (int bi = 0; bi < nb; bi++)
      for (int ci = 0; ci < CPB; ci++) f.wave[bi*CPB+ci] = b[bi];
    f.len = nb * CPB;
    f.data = d;
    f.acc_cyc = c;
    return f;
  endfunction

  function automatic int q_size(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic frame_t q_front(input int k);
    case (k)
      0: return q0[0];
      1: return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic q_pop(input int k);
    case (k)
      0: void'(q0.pop_front());
      1: void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  task automatic q_push(input int k, input frame_t f);
    case (k)
      0: q0.push_back(f);
      1: q1.push_back(f);
      default: q2.push_back(f);
    endcase
  endtask

  // Reference model: per instance, idle iff no cycles of the current frame remain.
  initial begin
    for (int k = 0; k < ND; k++) rem[k] = 0;
    forever begin
      @(posedge clk_50Mhz);
      for (int k = 0; k < ND; k++) begin
        if (!rst_n) rem[k] = 0;
        else if (rem[k] == 0 && tx_send) begin
          rem[k] = frame_bits(k) * CPB;
          q_push(k, build(k, tx_data, cyc));
        end else if (rem[k] > 0) rem[k] = rem[k] - 1;
      end
      if (!rst_n) begin
        q0.delete(); q1.delete(); q2.delete();
      end
      cyc = cyc + 1;
    end
  end

  // Monitor: capture tx while busy, compare the captured frame when tx_done pulses.
  initial begin
    logic [63:0] cap [ND];
    int cap_len [ND];
    logic [ND-1:0] pbusy;
    frame_t f;
    logic [63:0] mask;
    pbusy = '0;
    for (int k = 0; k < ND; k++) begin cap[k] = '0; cap_len[k] = 0; end
    forever begin
      @(negedge clk_50Mhz);
      for (int k = 0; k < ND; k++) begin
        if (!rst_n) begin
          chk(tx_w[k] && !busy_w[k] && !done_w[k], "reset_outputs", k,
              {61'd0, tx_w[k], busy_w[k], done_w[k]}, 64'h4);
          cap_len[k] = 0;
          pbusy[k] = 1'b0;
        end else begin
          if (busy_w[k]) begin
            if (!pbusy[k]) begin
              if (q_size(k) == 0) chk(1'b0, "busy_without_request", k, 64'd1, 64'd0);
              else begin
                f = q_front(k);
                chk(cyc == f.acc_cyc + 1, "start_latency", k, 64'(cyc - f.acc_cyc), 64'd1);
              end
            end
            if (cap_len[k] < 64) cap[k][cap_len[k]] = tx_w[k];
            cap_len[k]++;
            chk(!done_w[k], "done_while_busy", k, 64'(done_w[k]), 64'd0);
          end else begin
            chk(tx_w[k] == 1'b1, "idle_line_high", k, 64'(tx_w[k]), 64'd1);
            if (pbusy[k]) chk(done_w[k] == 1'b1, "done_at_frame_end", k, 64'(done_w[k]), 64'd1);
            if (done_w[k]) begin
              if (!pbusy[k]) chk(1'b0, "done_without_frame", k, 64'd1, 64'd0);
              if (q_size(k) == 0) chk(1'b0, "unexpected_done", k, 64'd1, 64'd0);
              else begin
                f = q_front(k);
                q_pop(k);
                mask = (f.len >= 64) ? '1 : ((64'd1 << f.len) - 64'd1);
                chk(cap_len[k] == f.len, "busy_length", k, 64'(cap_len[k]), 64'(f.len));
                chk(((cap[k] ^ f.wave) & mask) == 64'd0, "frame_bits", k, cap[k] & mask, f.wave);
              end
              cap_len[k] = 0;
            end
          end
          pbusy[k] = busy_w[k];
        end
      end
    end
  end

  task automatic send(input logic [7:0] d);
    @(negedge clk_50Mhz);
    tx_data = d;
    tx_send = 1'b1;
    @(negedge clk_50Mhz);
    tx_send = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int n = 0; n < 300 && !idle; n++) begin
      @(negedge clk_50Mhz);
      idle = (rem[0] == 0) && (rem[1] == 0) && (rem[2] == 0) &&
             (q_size(0) == 0) && (q_size(1) == 0) && (q_size(2) == 0);
    end
    if (!idle) chk(1'b0, "idle_timeout", 0, 64'd0, 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mode;
    int wait_c;
    repeat (3) @(negedge clk_50Mhz);
    rst_n = 1'b1;

    send(8'h0C); wait_idle();
    send(8'h0E); wait_idle();
    send(8'h03); wait_idle();

    // Request while busy must be dropped.
    send(8'hA5);
    repeat (9) @(negedge clk_50Mhz);
    tx_data = 8'h55; tx_send = 1'b1;
    @(negedge clk_50Mhz);
    tx_send = 1'b0; tx_data = 8'hFF;
    wait_idle();

    // Held request gives back-to-back frames with a fresh sample each time.
    @(negedge clk_50Mhz);
    tx_data = 8'h0C; tx_send = 1'b1;
    @(negedge clk_50Mhz);
    tx_data = 8'h03;
    repeat (48) @(negedge clk_50Mhz);
    tx_send = 1'b0;
    wait_idle();

    // Reset in the middle of the data bits.
    send(8'h0C);
    repeat (8) @(negedge clk_50Mhz);
    rst_n = 1'b0;
    #2;
    for (int k = 0; k < ND; k++) begin
      chk(tx_w[k] == 1'b1, "async_reset_tx", k, 64'(tx_w[k]), 64'd1);
      chk(busy_w[k] == 1'b0, "async_reset_busy", k, 64'(busy_w[k]), 64'd0);
    end
    repeat (2) @(negedge clk_50Mhz);
    rst_n = 1'b1;
    send(8'h0E); wait_idle();

    for (int it = 0; it < 40; it++) begin
      mode = $urandom_range(0, 3);
      repeat ($urandom_range(0, 3)) @(negedge clk_50Mhz);
      case (mode)
        0: send(8'($urandom));
        1: begin
          send(8'($urandom));
          repeat ($urandom_range(1, 30)) @(negedge clk_50Mhz);
          tx_data = 8'($urandom); tx_send = 1'b1;
          @(negedge clk_50Mhz);
          tx_send = 1'b0;
        end
        2: begin
          @(negedge clk_50Mhz);
          tx_data = 8'($urandom); tx_send = 1'b1;
          wait_c = $urandom_range(42, 80);
          for (int c = 0; c < wait_c; c++) begin
            @(negedge clk_50Mhz);
            tx_data = 8'($urandom);
          end
          tx_send = 1'b0;
        end
        default: begin
          send(8'($urandom));
          repeat (10) begin
            @(negedge clk_50Mhz);
            tx_data = 8'($urandom);
          end
        end
      endcase
      wait_idle();
    end

    repeat (5) @(negedge clk_50Mhz);
    for (int k = 0; k < ND; k++)
      chk(q_size(k) == 0, "missing_done", k, 64'(q_size(k)), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
